spi_master: RTL and testbench
=============================

# spi_master

Initiator end of the board-to-board SPI memory protocol that `spi_slave` answers: turns one-word read/write requests into SPI mode-0 frames, MSB first. Lets an FPGA node drive a peer's memory-mapped space (message memory, display buffers, display control) the way the RPi does today, and serves as the bench driver for `spi_slave`. Sits in the `clk` domain and exposes a valid/ready request port and a pulsed response port.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; legal range ≥ 1.
- `GAP_CYCLES`, 8: idle SCLK-low cycles between the command word and the read-data word, giving the slave time to fetch; legal range ≥ 1.
- `clk` in 1: system clock (CLOCK_33 domain).
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present; must be held until accepted.
- `req_ready` out 1: high only in IDLE; accept happens on `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 28: word address.
- `req_wdata` in 32: write data; ignored for reads.
- `resp_valid` out 1: one-cycle pulse when a frame completes.
- `resp_rdata` out 32: read data; updated only on read completion, held otherwise.
- `SPI_CLK` out 1: SCLK; idles low.
- `SPI_CS` out 1: active-low chip select.
- `SPI_MOSI` out 1: serial data to slave.
- `SPI_MISO` in 1: serial data from slave; already synchronous to `clk` at the board level.

## Operation
- Frame: CS low → command word `{req_we, 3'b000, req_addr}` (32 bits) → write: 32 bits of `req_wdata`; read: GAP phase, then 32 bits clocked with MOSI = 0 and MISO captured → CS high.
- Mode 0: MOSI changes only while SCLK is low; MISO is sampled in the `clk` cycle in which SCLK rises.
- States: IDLE → CS_SETUP (CLK_DIV cycles) → SHIFT_CMD (32 bits) → {write: SHIFT_DATA | read: GAP (GAP_CYCLES) → SHIFT_DATA} → CS_HOLD (CLK_DIV cycles) → CS_IDLE (CLK_DIV cycles, CS high, `req_ready` = 0) → IDLE.
- Each bit takes CLK_DIV cycles low, then CLK_DIV cycles high. The bit counter is 6 bits wide and clears at every word boundary.
- Request fields are latched on accept. Input changes after accept have no effect on the frame in progress.
- `req_valid` during a busy frame is ignored; it is not queued.
- Reset at any point, including mid-frame, aborts the frame. The next cycle shows IDLE state, SPI_CS = 1, SPI_CLK = 0, SPI_MOSI = 0, resp_valid = 0, req_ready = 1, resp_rdata = 0. No response is issued for the aborted frame.

## Timing
- All outputs are registered.
- Reset values: SPI_CS = 1, SPI_CLK = 0, SPI_MOSI = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0.
- Accept at edge N: at N+1, SPI_CS = 0, MOSI = command bit 31, req_ready = 0.
- First SCLK rise at N+1+CLK_DIV+CLK_DIV.
- CS-low duration:
  - write: CLK_DIV + 128·CLK_DIV + CLK_DIV cycles;
  - read: CLK_DIV + 64·CLK_DIV + GAP_CYCLES + 64·CLK_DIV + CLK_DIV cycles.
- `resp_valid` pulses in the same cycle SPI_CS returns high. For reads, `resp_rdata` is valid in that same cycle.
- `req_ready` rises CLK_DIV cycles after CS rises, so the minimum CS-high time between frames is CLK_DIV.
- After the last rising edge of a word, SCLK returns low CLK_DIV cycles later, before CS_HOLD begins.
- Half-period and gap counter width: $clog2(max(CLK_DIV, GAP_CYCLES)) + 1.

## Structure
- Shared package `spi_proto_pkg`, common to this block and `spi_slave`, holds:
  - `SPI_ADDR_W` = 28, `SPI_DATA_W` = 32, `SPI_CMD_W` = 32, `SPI_RW_BIT` = 31;
  - function `spi_make_cmd(we, addr)`;
  - `spi_master_state_t` enum.
- Sub-module `spi_sclk_gen`: half-period tick counter producing `rise`/`fall` strobes and the SCLK level; enabled only in SHIFT states.
- The top-level FSM, shift registers and bit counter live in `spi_master`.

## Test plan
- Post-reset idle: with no requests → CS = 1, SCLK = 0, MOSI = 0, req_ready = 1 steady for 100 cycles.
- Write, CLK_DIV = 2: addr 0x0000010, data 0xDEADBEEF.
  - MOSI bits captured on SCLK rises = 0x80000010 then 0xDEADBEEF.
  - CS low for exactly 260 cycles.
  - One resp_valid pulse; resp_rdata unchanged.
- Read against an `spi_slave` + RAM model: CLK_DIV = 2, GAP_CYCLES = 8, RAM[0x20] = 0x12345678.
  - Command word 0x00000020.
  - CS low 268 cycles.
  - resp_rdata = 0x12345678 on the resp_valid cycle.
- Back-to-back requests: req_valid held high across two writes → second accept exactly CLK_DIV cycles after the first CS rise; frames do not overlap.
- Mid-frame reset: reset asserted one cycle during bit 40 of a write → next cycle CS = 1, SCLK = 0, no resp_valid; a following read completes normally.
- CLK_DIV = 1, GAP_CYCLES = 1: read → SCLK toggles every cycle, CS low 131 cycles, data correct.

Source files
------------

// File: rtl/spi_proto_pkg.sv
// spi_proto_pkg
//   Definitions shared by the SPI memory-protocol initiator (spi_master) and
//   responder (spi_slave): word widths, command-word layout and the
//   initiator FSM state encoding.
//   Command word layout: {we, 3'b000, addr[27:0]}; bit 31 = 1 for write.
package spi_proto_pkg;

  localparam int SPI_ADDR_W = 28;
  localparam int SPI_DATA_W = 32;
  localparam int SPI_CMD_W  = 32;
  localparam int SPI_RW_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CS_SETUP   = 3'd1,
    ST_SHIFT_CMD  = 3'd2,
    ST_GAP        = 3'd3,
    ST_SHIFT_DATA = 3'd4,
    ST_CS_HOLD    = 3'd5,
    ST_CS_IDLE    = 3'd6
  } spi_master_state_t;

  // Build the 32-bit command word sent first in every frame.
  function automatic logic [SPI_CMD_W-1:0] spi_make_cmd(
    input logic                  we,
    input logic [SPI_ADDR_W-1:0] addr
  );
    return {we, 3'b000, addr};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
//   SCLK generator for the SPI initiator. While en is high it counts CLK_DIV
//   clk cycles per half-period and toggles the SCLK level; while en is low it
//   holds SCLK low with the counter cleared, so each enable starts with a
//   full low half-period.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en         : run the generator (SHIFT states only)
//   sclk       : registered SCLK level (idles low)
//   rise       : 1 in the clk cycle whose closing edge raises SCLK
//   fall       : 1 in the clk cycle whose closing edge lowers SCLK
module spi_sclk_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt_reg;
  logic             sclk_reg;
  logic             half_done;

  assign half_done = (half_cnt_reg == HALF_LAST);
  // Strobes are combinational so the FSM acts on the same edge that moves SCLK.
  assign rise = en && half_done && !sclk_reg;
  assign fall = en && half_done &&  sclk_reg;
  assign sclk = sclk_reg;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      half_cnt_reg <= '0;
      sclk_reg     <= 1'b0;
    end else if (half_done) begin
      half_cnt_reg <= '0;
      sclk_reg     <= ~sclk_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master
//   SPI mode-0 initiator for the board-to-board memory protocol. Converts a
//   one-word read/write request into a frame: CS low, 32-bit command word,
//   then either 32 bits of write data or (after a GAP_CYCLES idle gap) 32
//   bits of read data captured from MISO, then CS high. MSB first.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_we/addr/wdata   : request fields, latched on accept
//   resp_valid          : one-cycle pulse as CS returns high
//   resp_rdata          : read data, updated only when a read completes
//   SPI_CLK/CS/MOSI     : registered SPI outputs (SCLK idles low, CS active low)
//   SPI_MISO            : serial input, already synchronous to clk
module spi_master
  import spi_proto_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [SPI_DATA_W-1:0] resp_rdata,
  output logic                  SPI_CLK,
  output logic                  SPI_CS,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO
);

  localparam int MAX_DLY = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DLY) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  spi_master_state_t     state_reg;
  logic [CNT_W-1:0]      tmr_reg;
  logic [5:0]            bit_cnt_reg;
  logic [SPI_CMD_W-1:0]  tx_reg;
  logic [SPI_DATA_W-1:0] rx_reg;
  logic [SPI_DATA_W-1:0] wdata_reg;
  logic [SPI_DATA_W-1:0] rdata_reg;
  logic                  we_reg;
  logic                  cs_reg;
  logic                  mosi_reg;
  logic                  ready_reg;
  logic                  resp_valid_reg;

  logic                  sclk_en;
  logic                  sclk_w;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  last_bit;
  logic [SPI_CMD_W-1:0]  cmd_word;

  assign sclk_en  = (state_reg == ST_SHIFT_CMD) || (state_reg == ST_SHIFT_DATA);
  assign last_bit = (bit_cnt_reg == 6'd31);
  assign cmd_word = spi_make_cmd(req_we, req_addr);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (sclk_en),
    .sclk  (sclk_w),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      tmr_reg        <= '0;
      bit_cnt_reg    <= '0;
      tx_reg         <= '0;
      rx_reg         <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      we_reg         <= 1'b0;
      cs_reg         <= 1'b1;
      mosi_reg       <= 1'b0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && ready_reg) begin
            // First command bit goes out with CS so it is stable for the
            // whole setup time before the first rising edge.
            state_reg   <= ST_CS_SETUP;
            we_reg      <= req_we;
            wdata_reg   <= req_wdata;
            tx_reg      <= cmd_word;
            mosi_reg    <= cmd_word[SPI_RW_BIT];
            cs_reg      <= 1'b0;
            ready_reg   <= 1'b0;
            tmr_reg     <= '0;
            bit_cnt_reg <= '0;
          end
        end

        ST_CS_SETUP: begin
          if (tmr_reg == DIV_LAST) begin
            state_reg <= ST_SHIFT_CMD;
            tmr_reg   <= '0;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end

        ST_SHIFT_CMD: begin
          // Word boundaries are taken on the falling edge so SCLK is already
          // low when the next phase begins.
          if (sclk_fall) begin
            if (last_bit) begin
              bit_cnt_reg <= '0;
              if (we_reg) begin
                state_reg <= ST_SHIFT_DATA;
                tx_reg    <= wdata_reg;
                mosi_reg  <= wdata_reg[SPI_DATA_W-1];
              end else begin
                state_reg <= ST_GAP;
                tx_reg    <= '0;
                mosi_reg  <= 1'b0;
                tmr_reg   <= '0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= {tx_reg[SPI_CMD_W-2:0], 1'b0};
              mosi_reg    <= tx_reg[SPI_CMD_W-2];
            end
          end
        end

        ST_GAP: begin
          if (tmr_reg == GAP_LAST) begin
            state_reg <= ST_SHIFT_DATA;
            tmr_reg   <= '0;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end

        ST_SHIFT_DATA: begin
          if (sclk_rise) begin
            rx_reg <= {rx_reg[SPI_DATA_W-2:0], SPI_MISO};
          end
          if (sclk_fall) begin
            if (last_bit) begin
              state_reg   <= ST_CS_HOLD;
              bit_cnt_reg <= '0;
              mosi_reg    <= 1'b0;
              tmr_reg     <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= {tx_reg[SPI_CMD_W-2:0], 1'b0};
              mosi_reg    <= tx_reg[SPI_CMD_W-2];
            end
          end
        end

        ST_CS_HOLD: begin
          if (tmr_reg == DIV_LAST) begin
            state_reg      <= ST_CS_IDLE;
            cs_reg         <= 1'b1;
            resp_valid_reg <= 1'b1;
            tmr_reg        <= '0;
            if (!we_reg) begin
              rdata_reg <= rx_reg;
            end
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end

        ST_CS_IDLE: begin
          // Enforces a minimum CS-high time before the next accept.
          if (tmr_reg == DIV_LAST) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            tmr_reg   <= '0;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          cs_reg    <= 1'b1;
          ready_reg <= 1'b1;
          mosi_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign SPI_CLK    = sclk_w;
  assign SPI_CS     = cs_reg;
  assign SPI_MOSI   = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
//   Two initiators share one clock: instance 0 with CLK_DIV=2/GAP_CYCLES=8,
//   instance 1 with CLK_DIV=1/GAP_CYCLES=1. A behavioural slave + RAM model
//   per instance captures MOSI on SCLK rises and serves read data on MISO.
module tb_spi_master;
  import spi_proto_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [27:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        resp_valid[NI];
  logic [31:0] resp_rdata[NI];
  logic        spi_clk   [NI];
  logic        spi_cs    [NI];
  logic        spi_mosi  [NI];
  logic        spi_miso  [NI] = '{1'b0, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      spi_master #(
        .CLK_DIV    ((gi == 0) ? 2 : 1),
        .GAP_CYCLES ((gi == 0) ? 8 : 1)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_we     (req_we[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .resp_valid (resp_valid[gi]),
        .resp_rdata (resp_rdata[gi]),
        .SPI_CLK    (spi_clk[gi]),
        .SPI_CS     (spi_cs[gi]),
        .SPI_MOSI   (spi_mosi[gi]),
        .SPI_MISO   (spi_miso[gi])
      );
    end
  endgenerate

  // ---------------- slave / RAM model and bus monitor ----------------
  logic [31:0] ram [0:255];
  int          cs_cnt    [NI] = '{0, 0};
  int          cs_low_len[NI] = '{0, 0};
  int          bitn      [NI] = '{0, 0};
  int          rises     [NI] = '{0, 0};
  int          first_rise[NI] = '{0, 0};
  int          resp_cnt  [NI] = '{0, 0};
  int          viol      [NI] = '{0, 0};
  logic [31:0] cmd_word  [NI] = '{32'h0, 32'h0};
  logic [31:0] data_word [NI] = '{32'h0, 32'h0};
  logic [31:0] tx_word   [NI] = '{32'h0, 32'h0};
  logic        prev_cs   [NI] = '{1'b1, 1'b1};
  logic        prev_sclk [NI] = '{1'b0, 1'b0};
  logic        prev_mosi [NI] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (reset) ram[8'h20] = 32'h12345678;
    for (int i = 0; i < NI; i++) begin
      if (resp_valid[i]) resp_cnt[i]++;
      if (spi_clk[i] && spi_cs[i]) viol[i]++;
      if ((spi_mosi[i] != prev_mosi[i]) && spi_clk[i]) viol[i]++;
      if (!spi_cs[i]) begin
        if (prev_cs[i]) begin
          cs_cnt[i] = 1; bitn[i] = 0; rises[i] = 0; first_rise[i] = 0;
          cmd_word[i] = 32'h0; data_word[i] = 32'h0;
        end else begin
          cs_cnt[i]++;
        end
        if (spi_clk[i] && !prev_sclk[i]) begin
          rises[i]++;
          if (rises[i] == 1) first_rise[i] = cs_cnt[i];
          if (bitn[i] < 32) begin
            cmd_word[i] = {cmd_word[i][30:0], spi_mosi[i]};
            bitn[i]++;
            if (bitn[i] == 32 && !cmd_word[i][31]) begin
              tx_word[i]  = ram[cmd_word[i][7:0]];
              spi_miso[i] = tx_word[i][31];
            end
          end else if (bitn[i] < 64) begin
            data_word[i] = {data_word[i][30:0], spi_mosi[i]};
            bitn[i]++;
            tx_word[i]  = {tx_word[i][30:0], 1'b0};
            spi_miso[i] = cmd_word[i][31] ? 1'b0 : tx_word[i][31];
            if (bitn[i] == 64) begin
              spi_miso[i] = 1'b0;
              if (cmd_word[i][31]) ram[cmd_word[i][7:0]] = data_word[i];
            end
          end
        end
      end else begin
        if (!prev_cs[i]) cs_low_len[i] = cs_cnt[i];
        spi_miso[i] = 1'b0;
        bitn[i] = 0;
      end
      prev_cs[i]   = spi_cs[i];
      prev_sclk[i] = spi_clk[i];
      prev_mosi[i] = spi_mosi[i];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic        we;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_cmd;
    logic [31:0] exp_data;
    int          exp_cs;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_ready(input int i, output bit ok);
    int n = 0;
    while (!req_ready[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 2000);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int i  = v.inst;
    int cd = (v.inst == 0) ? 2 : 1;
    int n;
    int r0;
    bit ok;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = v.we;
    req_addr[i]  = v.addr;
    req_wdata[i] = v.wdata;
    wait_ready(i, ok);
    check({tag, " accept_timeout"}, 32'(ok), 32'd1);
    if (!ok) begin req_valid[i] = 1'b0; return; end
    r0 = resp_cnt[i];
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the frame must use the latched values.
    req_valid[i] = 1'b0;
    req_we[i]    = ~v.we;
    req_addr[i]  = ~v.addr;
    req_wdata[i] = ~v.wdata;
    check({tag, " cs_after_accept"},    32'(spi_cs[i]),    32'd0);
    check({tag, " ready_after_accept"}, 32'(req_ready[i]), 32'd0);
    check({tag, " mosi_first_bit"},     32'(spi_mosi[i]),  32'(v.exp_cmd[31]));
    n = 0;
    @(negedge clk);
    while (!resp_valid[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " resp_timeout"}, 32'(n < 2000), 32'd1);
    if (n >= 2000) return;
    check({tag, " cs_at_resp"}, 32'(spi_cs[i]), 32'd1);
    check({tag, " rdata"}, resp_rdata[i], v.exp_rdata);
    #1;
    check({tag, " cs_low_cycles"}, 32'(cs_low_len[i]), 32'(v.exp_cs));
    check({tag, " cmd_word"}, cmd_word[i], v.exp_cmd);
    check({tag, " data_word"}, data_word[i], v.exp_data);
    check({tag, " first_rise"}, 32'(first_rise[i]), 32'(2 * cd + 1));
    check({tag, " sclk_rises"}, 32'(rises[i]), 32'd64);
    @(negedge clk);
    check({tag, " resp_pulse_width"}, 32'(resp_valid[i]), 32'd0);
    #1;
    check({tag, " resp_count"}, 32'(resp_cnt[i] - r0), 32'd1);
    $display("frame %s inst%0d we=%0b addr=0x%07h cmd=0x%08h data=0x%08h cs_low=%0d rdata=0x%08h",
             tag, i, v.we, v.addr, cmd_word[i], data_word[i], cs_low_len[i], resp_rdata[i]);
  endtask

  initial begin
    int  bad;
    int  n;
    int  k;
    int  r0;
    bit  ok;
    vec_t rv;

    //               inst we addr         wdata          exp_cmd        exp_data       cs   exp_rdata
    vecs[0] = '{0, 1'b1, 28'h0000010, 32'hDEADBEEF, 32'h80000010, 32'hDEADBEEF, 260, 32'h00000000};
    vecs[1] = '{0, 1'b0, 28'h0000020, 32'hFFFFFFFF, 32'h00000020, 32'h00000000, 268, 32'h12345678};
    vecs[2] = '{0, 1'b1, 28'h0000030, 32'hA5A50F0F, 32'h80000030, 32'hA5A50F0F, 260, 32'h12345678};
    vecs[3] = '{0, 1'b0, 28'h0000030, 32'h5A5A5A5A, 32'h00000030, 32'h00000000, 268, 32'hA5A50F0F};
    vecs[4] = '{0, 1'b0, 28'h0000010, 32'h00000000, 32'h00000010, 32'h00000000, 268, 32'hDEADBEEF};
    vecs[5] = '{1, 1'b0, 28'h0000020, 32'h00000000, 32'h00000020, 32'h00000000, 131, 32'h12345678};
    vecs[6] = '{1, 1'b1, 28'hFFFFFFF, 32'h00000001, 32'h8FFFFFFF, 32'h00000001, 130, 32'h12345678};
    vecs[7] = '{1, 1'b0, 28'hFFFFFFF, 32'h00000000, 32'h0FFFFFFF, 32'h00000000, 131, 32'h00000001};
    vecs[8] = '{1, 1'b1, 28'h0000055, 32'h80000000, 32'h80000055, 32'h80000000, 130, 32'h00000001};
    vecs[9] = '{1, 1'b0, 28'h0000055, 32'h00000000, 32'h00000055, 32'h00000000, 131, 32'h80000000};

    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_cs%0d", i),    32'(spi_cs[i]),     32'd1);
      check($sformatf("reset_sclk%0d", i),  32'(spi_clk[i]),    32'd0);
      check($sformatf("reset_mosi%0d", i),  32'(spi_mosi[i]),   32'd0);
      check($sformatf("reset_ready%0d", i), 32'(req_ready[i]),  32'd1);
      check($sformatf("reset_resp%0d", i),  32'(resp_valid[i]), 32'd0);
      check($sformatf("reset_rdata%0d", i), resp_rdata[i],      32'h0);
    end

    // Idle steady for 100 cycles
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        if (spi_cs[i] !== 1'b1 || spi_clk[i] !== 1'b0 || spi_mosi[i] !== 1'b0 || req_ready[i] !== 1'b1)
          bad++;
    end
    check("idle_100_cycles", 32'(bad), 32'd0);

    for (int v = 0; v < 10; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back writes with req_valid held high on instance 0
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 28'h0000060; req_wdata[0] = 32'hCAFEF00D;
    wait_ready(0, ok);
    check("b2b accept1_timeout", 32'(ok), 32'd1);
    r0 = resp_cnt[0];
    @(posedge clk);
    #1;
    req_addr[0] = 28'h0000061; req_wdata[0] = 32'h0BADF00D;
    n = 0;
    @(negedge clk);
    while (spi_cs[0] !== 1'b1 && n < 2000) begin
      if (req_ready[0]) bad++;
      @(negedge clk);
      n++;
    end
    check("b2b cs_rise_timeout", 32'(n < 2000), 32'd1);
    #1;
    check("b2b frame1_cmd",  cmd_word[0],  32'h80000060);
    check("b2b frame1_data", data_word[0], 32'hCAFEF00D);
    k = 0;
    while (!req_ready[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b ready_delay", 32'(k), 32'd2);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check("b2b cs_after_accept2", 32'(spi_cs[0]), 32'd0);
    n = 0;
    @(negedge clk);
    while (!resp_valid[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b2b resp2_timeout", 32'(n < 2000), 32'd1);
    #1;
    check("b2b frame2_cmd",    cmd_word[0],  32'h80000061);
    check("b2b frame2_data",   data_word[0], 32'h0BADF00D);
    check("b2b frame2_cs_low", 32'(cs_low_len[0]), 32'd260);
    check("b2b resp_count",    32'(resp_cnt[0] - r0), 32'd2);
    $display("b2b inst0 ready_delay=%0d frame2 cmd=0x%08h data=0x%08h", k, cmd_word[0], data_word[0]);

    // Mid-frame reset during a write on instance 0
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 28'h0000040; req_wdata[0] = 32'h11111111;
    wait_ready(0, ok);
    check("abort accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    r0 = resp_cnt[0];
    n = 0;
    while (bitn[0] < 40 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort bit40_timeout", 32'(n < 2000), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort cs",    32'(spi_cs[0]),     32'd1);
    check("abort sclk",  32'(spi_clk[0]),    32'd0);
    check("abort mosi",  32'(spi_mosi[0]),   32'd0);
    check("abort ready", 32'(req_ready[0]),  32'd1);
    check("abort resp",  32'(resp_valid[0]), 32'd0);
    check("abort rdata", resp_rdata[0],      32'h0);
    repeat (20) @(negedge clk);
    #1;
    check("abort no_resp", 32'(resp_cnt[0] - r0), 32'd0);
    $display("abort inst0 after %0d bits, cs=%0b sclk=%0b", 40, spi_cs[0], spi_clk[0]);
    rv = '{0, 1'b0, 28'h0000020, 32'h0, 32'h00000020, 32'h00000000, 268, 32'h12345678};
    run_frame(rv, "post_abort_read");

    for (int i = 0; i < NI; i++)
      check($sformatf("protocol_violations%0d", i), 32'(viol[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
